// File: rtl/huff_hist_sort.sv
// rtl/huff_hist_sort.sv - frame histogram of gray symbols followed by an odd-even transposition sort
//
// Counts FRAME_LEN accepted samples into N_SYM saturating symbol bins plus an
// out-of-range bin, presents the raw histogram for one cycle, then sorts
// (count, symbol) pairs descending by count (ties: lower symbol first) with one
// odd-even transposition pass per cycle and holds the result until consumed.
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous active-low reset
//   gray_valid  sample valid
//   gray_data   sample value (symbols are 1..N_SYM, anything else is out of range)
//   gray_ready  block accepts samples (READ state, reset released)
//   CNT_valid   one-cycle strobe, raw histogram final
//   CNT         raw counts, slice k-1 holds symbol k
//   OOR_CNT     count of out-of-range samples
//   sort_valid  sorted result valid (HOLD state)
//   sort_ready  downstream accepts the sorted result
//   SCNT        counts sorted descending, slice 0 largest
//   SSYM        symbol index matching each SCNT slice
module huff_hist_sort #(
  parameter int N_SYM     = 6,
  parameter int DATA_W    = 8,
  parameter int CW        = 8,
  parameter int FRAME_LEN = 100,
  localparam int SW       = $clog2(N_SYM + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                gray_valid,
  input  logic [DATA_W-1:0]   gray_data,
  output logic                gray_ready,
  output logic                CNT_valid,
  output logic [N_SYM*CW-1:0] CNT,
  output logic [CW-1:0]       OOR_CNT,
  output logic                sort_valid,
  input  logic                sort_ready,
  output logic [N_SYM*CW-1:0] SCNT,
  output logic [N_SYM*SW-1:0] SSYM
);

  typedef enum logic [1:0] {READ, CNT_OUT, SORT, HOLD} state_t;

  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [15:0]   LAST_SAMPLE = 16'(FRAME_LEN - 1);
  localparam logic [SW-1:0] LAST_PASS   = SW'(N_SYM - 1);

  state_t state, state_nxt;

  logic [CW-1:0] cnt     [N_SYM];
  logic [CW-1:0] oor_cnt;
  logic [15:0]   samp_cnt;
  logic [SW-1:0] pass_cnt;

  // Working sort array and the result of the current pass applied to it.
  logic [CW-1:0] srt_cnt [N_SYM];
  logic [SW-1:0] srt_sym [N_SYM];
  logic [CW-1:0] nxt_cnt [N_SYM];
  logic [SW-1:0] nxt_sym [N_SYM];

  // Published result; only updated when a sort completes so SCNT/SSYM never
  // show a partially sorted array.
  logic [CW-1:0] out_cnt [N_SYM];
  logic [SW-1:0] out_sym [N_SYM];

  logic accept;
  logic in_range;
  logic last_sample;
  logic last_pass;

  assign accept      = gray_valid && gray_ready;
  assign in_range    = (gray_data != '0) && (32'(gray_data) <= 32'(N_SYM));
  assign last_sample = accept && (samp_cnt == LAST_SAMPLE);
  assign last_pass   = (pass_cnt == LAST_PASS);

  always_ff @(posedge clk) begin
    if (!reset) state <= READ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    gray_ready = 1'b0;
    CNT_valid  = 1'b0;
    sort_valid = 1'b0;
    case (state)
      READ: begin
        gray_ready = reset;
        if (last_sample) state_nxt = CNT_OUT;
      end
      CNT_OUT: begin
        CNT_valid = 1'b1;
        state_nxt = SORT;
      end
      SORT: begin
        if (last_pass) state_nxt = HOLD;
      end
      HOLD: begin
        sort_valid = 1'b1;
        if (sort_ready) state_nxt = READ;
      end
      default: state_nxt = READ;
    endcase
  end

  // One transposition pass: even passes compare pairs (0,1),(2,3)..., odd
  // passes (1,2),(3,4).... Pairs within a pass are disjoint, so every compare
  // reads the pre-pass array.
  always_comb begin
    for (int k = 0; k < N_SYM; k++) begin
      nxt_cnt[k] = srt_cnt[k];
      nxt_sym[k] = srt_sym[k];
    end
    for (int i = 0; i < N_SYM - 1; i++) begin
      if (((i % 2) == 1) == pass_cnt[0]) begin
        if ((srt_cnt[i] < srt_cnt[i+1]) ||
            ((srt_cnt[i] == srt_cnt[i+1]) && (srt_sym[i] > srt_sym[i+1]))) begin
          nxt_cnt[i]   = srt_cnt[i+1];
          nxt_sym[i]   = srt_sym[i+1];
          nxt_cnt[i+1] = srt_cnt[i];
          nxt_sym[i+1] = srt_sym[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < N_SYM; k++) begin
        cnt[k]     <= '0;
        srt_cnt[k] <= '0;
        srt_sym[k] <= '0;
        out_cnt[k] <= '0;
        out_sym[k] <= '0;
      end
      oor_cnt  <= '0;
      samp_cnt <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        READ: begin
          if (accept) begin
            samp_cnt <= samp_cnt + 16'd1;
            if (in_range) begin
              for (int k = 0; k < N_SYM; k++) begin
                if ((32'(gray_data) == 32'(k + 1)) && (cnt[k] != CNT_MAX))
                  cnt[k] <= cnt[k] + CW'(1);
              end
            end else if (oor_cnt != CNT_MAX) begin
              oor_cnt <= oor_cnt + CW'(1);
            end
          end
        end
        CNT_OUT: begin
          for (int k = 0; k < N_SYM; k++) begin
            srt_cnt[k] <= cnt[k];
            srt_sym[k] <= SW'(k + 1);
          end
          pass_cnt <= '0;
        end
        SORT: begin
          for (int k = 0; k < N_SYM; k++) begin
            srt_cnt[k] <= nxt_cnt[k];
            srt_sym[k] <= nxt_sym[k];
            if (last_pass) begin
              out_cnt[k] <= nxt_cnt[k];
              out_sym[k] <= nxt_sym[k];
            end
          end
          pass_cnt <= pass_cnt + SW'(1);
        end
        HOLD: begin
          if (sort_ready) begin
            for (int k = 0; k < N_SYM; k++) cnt[k] <= '0;
            oor_cnt  <= '0;
            samp_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < N_SYM; g++) begin : g_pack
    assign CNT[g*CW +: CW]  = cnt[g];
    assign SCNT[g*CW +: CW] = out_cnt[g];
    assign SSYM[g*SW +: SW] = out_sym[g];
  end

  assign OOR_CNT = oor_cnt;

endmodule

// File: tb/tb_huff_hist_sort.sv
// tb/tb_huff_hist_sort.sv - randomized self-checking bench for huff_hist_sort
module tb_huff_hist_sort;

  localparam int N   = 6;
  localparam int CW  = 8;
  localparam int FL  = 100;
  localparam int SW  = 3;
  localparam int SCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            gray_valid;
  logic [7:0]      gray_data;
  logic            gray_ready;
  logic            CNT_valid;
  logic [N*CW-1:0] CNT;
  logic [CW-1:0]   OOR_CNT;
  logic            sort_valid;
  logic            sort_ready;
  logic [N*CW-1:0] SCNT;
  logic [N*SW-1:0] SSYM;

  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_ready;
  logic             s_cnt_valid;
  logic [N*SCW-1:0] s_cnt;
  logic [SCW-1:0]   s_oor;
  logic             s_sort_valid;
  logic             s_sort_ready;
  logic [N*SCW-1:0] s_scnt;
  logic [N*SW-1:0]  s_ssym;

  huff_hist_sort #(.N_SYM(N), .DATA_W(8), .CW(CW), .FRAME_LEN(FL)) u_dut (
    .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
    .gray_ready(gray_ready), .CNT_valid(CNT_valid), .CNT(CNT), .OOR_CNT(OOR_CNT),
    .sort_valid(sort_valid), .sort_ready(sort_ready), .SCNT(SCNT), .SSYM(SSYM)
  );

  huff_hist_sort #(.N_SYM(N), .DATA_W(8), .CW(SCW), .FRAME_LEN(FL)) u_sat (
    .clk(clk), .reset(reset), .gray_valid(s_valid), .gray_data(s_data),
    .gray_ready(s_ready), .CNT_valid(s_cnt_valid), .CNT(s_cnt), .OOR_CNT(s_oor),
    .sort_valid(s_sort_valid), .sort_ready(s_sort_ready), .SCNT(s_scnt), .SSYM(s_ssym)
  );

  int n_checks = 0;
  int n_errors = 0;

  int frame_q [FL];
  int m_cnt [N];
  int m_oor;
  logic [N*CW-1:0] e_cnt, e_scnt;
  logic [N*SW-1:0] e_ssym;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Histogram and ranking computed straight from the frame contents.
  task automatic build_model();
    bit used [N];
    int best;
    for (int k = 0; k < N; k++) begin m_cnt[k] = 0; used[k] = 1'b0; end
    m_oor = 0;
    foreach (frame_q[i]) begin
      if (frame_q[i] >= 1 && frame_q[i] <= N) m_cnt[frame_q[i]-1]++;
      else m_oor++;
    end
    for (int k = 0; k < N; k++) if (m_cnt[k] > 255) m_cnt[k] = 255;
    if (m_oor > 255) m_oor = 255;
    for (int k = 0; k < N; k++) e_cnt[k*CW +: CW] = CW'(m_cnt[k]);
    for (int r = 0; r < N; r++) begin
      best = -1;
      for (int k = 0; k < N; k++)
        if (!used[k] && (best < 0 || m_cnt[k] > m_cnt[best])) best = k;
      used[best] = 1'b1;
      e_scnt[r*CW +: CW] = CW'(m_cnt[best]);
      e_ssym[r*SW +: SW] = SW'(best + 1);
    end
  endtask

  task automatic shuffle();
    int j, t;
    for (int i = FL - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = frame_q[i]; frame_q[i] = frame_q[j]; frame_q[j] = t;
    end
  endtask

  task automatic fill_basic();
    int reps [N] = '{10, 20, 30, 15, 15, 10};
    int p = 0;
    for (int k = 0; k < N; k++) repeat (reps[k]) begin frame_q[p] = k + 1; p++; end
    shuffle();
  endtask

  task automatic fill_oor();
    int v;
    for (int i = 0; i < 90; i++) frame_q[i] = 2;
    for (int i = 90; i < FL; i++) begin
      v = $urandom_range(0, 2);
      frame_q[i] = (v == 0) ? 0 : (v == 1) ? 7 : $urandom_range(7, 255);
    end
    shuffle();
  endtask

  task automatic fill_random();
    for (int i = 0; i < FL; i++)
      frame_q[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(1, N);
  endtask

  // Offers frame_q until FL samples are accepted; sort_ready toggles randomly
  // meanwhile since it must be ignored outside HOLD.
  task automatic send_frame(input bit gaps);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < FL && guard < 1000) begin
      gray_data  = 8'(frame_q[idx]);
      gray_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      sort_ready = 1'($urandom_range(0, 1));
      acc = gray_valid && gray_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    sort_ready = 1'b0;
    check_eq("accepted_samples", 64'(idx), 64'(FL));
  endtask

  task automatic finish_frame(input int hold_cyc, input bit basic);
    int lat = 0;
    gray_valid = 1'b1;
    gray_data  = 8'($urandom_range(0, 255));
    check_eq("cnt_valid", 64'(CNT_valid), 64'd1);
    check_eq("ready_low_after_frame", 64'(gray_ready), 64'd0);
    check_eq("cnt", 64'(CNT), 64'(e_cnt));
    check_eq("oor_cnt", 64'(OOR_CNT), 64'(m_oor));
    if (basic) check_eq("basic_cnt_const", 64'(CNT),
                        64'({8'd10, 8'd15, 8'd15, 8'd30, 8'd20, 8'd10}));
    while (!sort_valid && lat < 40) begin
      gray_data = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check_eq("cnt_valid_one_cycle", 64'(CNT_valid), 64'd0);
    end
    check_eq("sort_latency", 64'(lat), 64'(N + 1));
    check_eq("scnt", 64'(SCNT), 64'(e_scnt));
    check_eq("ssym", 64'(SSYM), 64'(e_ssym));
    if (basic) begin
      check_eq("basic_scnt_const", 64'(SCNT), 64'({8'd10, 8'd10, 8'd15, 8'd15, 8'd20, 8'd30}));
      check_eq("basic_ssym_const", 64'(SSYM), 64'({3'd6, 3'd1, 3'd5, 3'd4, 3'd2, 3'd3}));
    end
    repeat (hold_cyc) begin
      gray_data = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    check_eq("hold_sort_valid", 64'(sort_valid), 64'd1);
    check_eq("hold_ready_low", 64'(gray_ready), 64'd0);
    check_eq("hold_cnt", 64'(CNT), 64'(e_cnt));
    check_eq("hold_oor", 64'(OOR_CNT), 64'(m_oor));
    check_eq("hold_scnt", 64'(SCNT), 64'(e_scnt));
    check_eq("hold_ssym", 64'(SSYM), 64'(e_ssym));
    gray_valid = 1'b0;
    sort_ready = 1'b1;
    @(posedge clk); #1;
    sort_ready = 1'b0;
    check_eq("clear_ready", 64'(gray_ready), 64'd1);
    check_eq("clear_sort_valid", 64'(sort_valid), 64'd0);
    check_eq("clear_cnt", 64'(CNT), 64'd0);
    check_eq("clear_oor", 64'(OOR_CNT), 64'd0);
    check_eq("kept_scnt", 64'(SCNT), 64'(e_scnt));
    check_eq("kept_ssym", 64'(SSYM), 64'(e_ssym));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc_n = 0;
    int g = 0;
    bit acc;
    bit saw_sv = 1'b0;
    logic [N*SW-1:0] e_sym_seq;

    reset = 1'b0; gray_valid = 1'b0; gray_data = '0; sort_ready = 1'b0;
    s_valid = 1'b0; s_data = '0; s_sort_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", 64'(gray_ready), 64'd0);
    check_eq("rst_cnt_valid", 64'(CNT_valid), 64'd0);
    check_eq("rst_sort_valid", 64'(sort_valid), 64'd0);
    check_eq("rst_cnt", 64'(CNT), 64'd0);
    check_eq("rst_scnt", 64'(SCNT), 64'd0);
    check_eq("rst_ssym", 64'(SSYM), 64'd0);
    reset = 1'b1;
    #1;
    check_eq("ready_after_release", 64'(gray_ready), 64'd1);

    // Saturation at CW=4 on the second instance; main instance idles.
    s_valid = 1'b1; s_data = 8'd1;
    while (!s_cnt_valid && g < 500) begin
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      if (acc) acc_n++;
      g++;
    end
    s_valid = 1'b0;
    check_eq("sat_accepted", 64'(acc_n), 64'(FL));
    check_eq("sat_cnt", 64'(s_cnt), 64'd15);
    check_eq("sat_oor", 64'(s_oor), 64'd0);
    repeat (N + 1) @(posedge clk);
    #1;
    for (int r = 0; r < N; r++) e_sym_seq[r*SW +: SW] = SW'(r + 1);
    check_eq("sat_sort_valid", 64'(s_sort_valid), 64'd1);
    check_eq("sat_scnt", 64'(s_scnt), 64'd15);
    check_eq("sat_ssym", 64'(s_ssym), 64'(e_sym_seq));
    check_eq("idle_cnt", 64'(CNT), 64'd0);
    check_eq("idle_scnt", 64'(SCNT), 64'd0);

    fill_basic();  build_model(); send_frame(1'b0); finish_frame(3, 1'b1);
    fill_oor();    build_model(); send_frame(1'b1); finish_frame(20, 1'b0);
    for (int f = 0; f < 3; f++) begin
      fill_random(); build_model(); send_frame(1'b1); finish_frame($urandom_range(0, 25), 1'b0);
    end

    // Reset while sorting: everything discarded.
    fill_random(); build_model(); send_frame(1'b0);
    gray_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("midsort_rst_ready", 64'(gray_ready), 64'd0);
    check_eq("midsort_rst_sort_valid", 64'(sort_valid), 64'd0);
    check_eq("midsort_rst_cnt", 64'(CNT), 64'd0);
    check_eq("midsort_rst_oor", 64'(OOR_CNT), 64'd0);
    check_eq("midsort_rst_scnt", 64'(SCNT), 64'd0);
    check_eq("midsort_rst_ssym", 64'(SSYM), 64'd0);
    reset = 1'b1;
    #1;
    check_eq("midsort_ready_after", 64'(gray_ready), 64'd1);
    repeat (12) begin
      @(posedge clk); #1;
      if (sort_valid) saw_sv = 1'b1;
    end
    check_eq("midsort_no_sort_valid", 64'(saw_sv), 64'd0);
    fill_random(); build_model(); send_frame(1'b1); finish_frame(5, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
